ram_dp_init: RTL and testbench
==============================

Name: ram_dp_init

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock. It generalises the existing single-lane memory with:
- per-lane write enables
- selectable read-during-write behaviour
- an optional output register stage
- a read-valid strobe
- a hardware init sequencer that fills every location after reset or on request

It sits behind datapath blocks as local scratch/lookup storage.

Parameters:
MEM_SIZE, 6, address width; depth = 2**MEM_SIZE.
DATA_W, 10, data word width.
LANES, 2, number of write lanes; DATA_W % LANES must be 0; lane width LW = DATA_W/LANES.
RDW_MODE, 0, same-address read/write in one cycle: 0 = old data, 1 = new data (forwarded).
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2.
INIT_VAL, 0, DATA_W-bit value written to every location by the init sequencer.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  request re-initialisation; sampled only in READY.
write  in  1  write strobe.
wr_lane_en  in  LANES  per-lane write enable; lane i = datain[i*LW +: LW].
addr_w  in  MEM_SIZE  write address.
datain  in  DATA_W  write data.
read  in  1  read strobe.
addr_r  in  MEM_SIZE  read address.
dataout  out  DATA_W  read data, registered.
rd_valid  out  1  dataout carries the result of a read in this cycle.
busy  out  1  init sequencer active; user accesses ignored.

Behaviour:
- Reset (rst_n=0, async): dataout=0, rd_valid=0, busy=1, state=INIT, init counter=0, output pipeline cleared. Memory contents are not reset directly; the sequencer overwrites them.
- FSM states: INIT, READY.
  - INIT: each cycle writes INIT_VAL to mem[cnt] on all lanes, then cnt++. When cnt = 2**MEM_SIZE-1 is written, go to READY next cycle. INIT lasts exactly 2**MEM_SIZE cycles after rst_n deasserts.
  - busy=1 throughout INIT; it falls on the first READY cycle.
  - READY with clear=1: go to INIT and reset cnt=0. Any write/read in that same cycle is still performed.
- During INIT:
  - write and read are ignored and not queued.
  - rd_valid=0.
  - dataout holds its last value; after reset that value is 0.
- Write (READY): at the edge with write=1, for each lane i with wr_lane_en[i]=1, mem[addr_w] lane i <= datain lane i. Disabled lanes are unchanged. write=1 with wr_lane_en=0 is a no-op.
- Read (READY, OUT_REG=0):
  - At the edge with read=1, dataout <= mem[addr_r] and rd_valid=1 for the following cycle.
  - With read=0, dataout holds and rd_valid=0.
- OUT_REG=1: one more register stage. dataout and rd_valid appear one cycle later. Holding and clearing rules apply per stage.
- Read-during-write, same cycle and addr_r == addr_w, both strobes high:
  - RDW_MODE=0: dataout = contents before the write.
  - RDW_MODE=1: dataout = merged word. Enabled lanes come from datain; disabled lanes from old contents.
  - Different addresses: independent, no interaction.
- Write and clear in the same cycle: the write lands, then init overwrites it with INIT_VAL.
- Reset mid-INIT or mid-read: everything restarts from the reset values, and the in-flight read is discarded with rd_valid=0.
- Address wrap: addresses are MEM_SIZE bits with no out-of-range case. The init counter is MEM_SIZE+1 bits wide internally, or a terminal flag is used, so the last location is written exactly once.

Decomposition:
- Package ram_pkg:
  - state enum {INIT, READY}
  - RDW_OLD=0 and RDW_NEW=1 constants
  - a lane-width helper function
- One natural sub-module, ram_init_seq: the FSM and counter. Outputs busy, init_we and init_addr, which are muxed onto the write port inside ram_dp_init.
- The storage array and output pipeline stay in the top module.

Test Plan:
1. Release rst_n and hold write/read=1 for 70 cycles (MEM_SIZE=6, INIT_VAL=10'h155) -> busy=1 for exactly 64 cycles; rd_valid=0 throughout INIT. After INIT, read mem[0], mem[37] and mem[63] -> each 10'h155, rd_valid=1, latency 1.
2. Default params: write 12 to addr 0, then read addr 0 -> 12 one cycle later. Same cycle write 14 / read addr 0 -> 12 (old). Next read -> 14.
3. RDW_MODE=1: mem[1]=36, then same cycle write 38 / read addr 1 -> dataout=38. Repeat with wr_lane_en=2'b01, datain=10'h3FF on mem=10'h000 -> dataout=10'h01F, and mem[1]=10'h01F afterwards.
4. Lane enables: mem[5]=0, write 10'h3FF with wr_lane_en=2'b10 -> read 10'h3E0; a write with wr_lane_en=2'b00 leaves it unchanged.
5. OUT_REG=1: write 55 to addr 2, read addr 2 -> rd_valid and dataout=55 exactly 2 cycles after the read edge; no read -> dataout holds 55, rd_valid=0.
6. Pulse clear in READY after writing 99 to addr 3 -> busy=1 for 64 cycles; then read addr 3 -> INIT_VAL. Assert rst_n=0 mid-INIT at cnt=20 -> dataout=0 and busy=1 immediately; full 64-cycle INIT restarts.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port init RAM.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  function automatic int unsigned lane_width(input int unsigned data_w,
                                             input int unsigned lanes);
    return data_w / lanes;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Init sequencer: walks every address once after reset or a clear request.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  output logic                o_busy,
  output logic                o_init_we,
  output logic [MEM_SIZE-1:0] o_init_addr
);

  localparam int unsigned CNT_W = MEM_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << MEM_SIZE) - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  // Extra counter bit keeps the terminal compare unambiguous at the top address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        INIT: begin
          if (r_cnt == LAST) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        READY: begin
          if (i_clear) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_init_we   = r_busy;
  assign o_init_addr = r_cnt[MEM_SIZE-1:0];

endmodule

// File: rtl/ram_dp_init.sv
// Simple-dual-port RAM with lane enables, RDW select, optional output stage
// and a hardware fill sequencer.
module ram_dp_init
  import ram_pkg::*;
#(
  parameter int unsigned        MEM_SIZE = 6,
  parameter int unsigned        DATA_W   = 10,
  parameter int unsigned        LANES    = 2,
  parameter int unsigned        RDW_MODE = RDW_OLD,
  parameter int unsigned        OUT_REG  = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                write,
  input  logic [LANES-1:0]    wr_lane_en,
  input  logic [MEM_SIZE-1:0] addr_w,
  input  logic [DATA_W-1:0]   datain,
  input  logic                read,
  input  logic [MEM_SIZE-1:0] addr_r,
  output logic [DATA_W-1:0]   dataout,
  output logic                rd_valid,
  output logic                busy
);

  localparam int unsigned LW    = lane_width(DATA_W, LANES);
  localparam int unsigned DEPTH = 1 << MEM_SIZE;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_q1;
  logic                r_v1;

  logic                w_busy;
  logic                w_init_we;
  logic [MEM_SIZE-1:0] w_init_addr;
  logic                w_we;
  logic [LANES-1:0]    w_lane_en;
  logic [MEM_SIZE-1:0] w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_rd;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_rdata;

  ram_init_seq #(
    .MEM_SIZE (MEM_SIZE)
  ) u_init_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clear),
    .o_busy      (w_busy),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr)
  );

  // Sequencer owns the write port while busy; user accesses are dropped.
  assign w_we      = w_init_we | (write & ~w_busy);
  assign w_lane_en = w_init_we ? {LANES{1'b1}} : wr_lane_en;
  assign w_waddr   = w_init_we ? w_init_addr : addr_w;
  assign w_wdata   = w_init_we ? INIT_VAL : datain;
  assign w_rd      = read & ~w_busy;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (w_lane_en[i]) r_mem[w_waddr][i*LW +: LW] <= w_wdata[i*LW +: LW];
      end
    end
  end

  assign w_old = r_mem[addr_r];

  // Forwarded word for same-address read-during-write.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < int'(LANES); i++) begin
      if (wr_lane_en[i]) w_merged[i*LW +: LW] = datain[i*LW +: LW];
    end
  end

  assign w_rdata = ((RDW_MODE == RDW_NEW) && write && (addr_w == addr_r)) ? w_merged : w_old;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_rd;
      if (w_rd) r_q1 <= w_rdata;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_q2;
    logic              r_v2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_q2 <= r_q1;
      end
    end

    assign dataout  = r_q2;
    assign rd_valid = r_v2;
  end else begin : g_noreg
    assign dataout  = r_q1;
    assign rd_valid = r_v1;
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: three parameterisations share one stimulus stream.
module tb_ram_dp_init;

  localparam int DEPTH = 64;
  localparam int LW    = 5;
  localparam int NK    = 3;
  localparam int P_RDW [NK] = '{0, 1, 0};
  localparam int P_LAT [NK] = '{1, 1, 2};
  localparam logic [9:0] P_INIT [NK] = '{10'h155, 10'h000, 10'h155};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [1:0] lane = 2'b00;
  logic [5:0] aw = '0;
  logic [5:0] ar = '0;
  logic [9:0] din = '0;

  logic [9:0] dout [NK];
  logic       rv   [NK];
  logic       bz   [NK];

  always #5 clk = ~clk;

  ram_dp_init #(.MEM_SIZE(6), .DATA_W(10), .LANES(2), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(10'h155))
  u_dut0 (.clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .wr_lane_en(lane), .addr_w(aw),
          .datain(din), .read(read), .addr_r(ar), .dataout(dout[0]), .rd_valid(rv[0]), .busy(bz[0]));

  ram_dp_init #(.MEM_SIZE(6), .DATA_W(10), .LANES(2), .RDW_MODE(1), .OUT_REG(0), .INIT_VAL(10'h000))
  u_dut1 (.clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .wr_lane_en(lane), .addr_w(aw),
          .datain(din), .read(read), .addr_r(ar), .dataout(dout[1]), .rd_valid(rv[1]), .busy(bz[1]));

  ram_dp_init #(.MEM_SIZE(6), .DATA_W(10), .LANES(2), .RDW_MODE(0), .OUT_REG(1), .INIT_VAL(10'h155))
  u_dut2 (.clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .wr_lane_en(lane), .addr_w(aw),
          .datain(din), .read(read), .addr_r(ar), .dataout(dout[2]), .rd_valid(rv[2]), .busy(bz[2]));

  typedef struct {
    int         k;
    int         due;
    logic [9:0] d;
  } sb_t;

  typedef struct {
    logic       wr;
    logic [1:0] en;
    logic [5:0] aw;
    logic [9:0] di;
    logic       rd;
    logic [5:0] ar;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
  } vec_t;

  sb_t        sbq [$];
  vec_t       vt  [$];
  logic [9:0] mm    [NK][DEPTH];
  int         mcnt  [NK];
  bit         mbusy [NK];
  logic [9:0] mlast [NK];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      mbusy[k] = 1'b1;
      mcnt[k]  = 0;
      mlast[k] = '0;
    end
    sbq.delete();
  endtask

  // Behavioural reference: fill sequencer, lane writes, RDW choice, latency.
  always @(posedge clk or negedge rst_n) begin
    logic [9:0] old_w, new_w, rd_w;
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      for (int k = 0; k < NK; k++) begin
        if (mbusy[k]) begin
          mm[k][mcnt[k]] = P_INIT[k];
          if (mcnt[k] == DEPTH - 1) mbusy[k] = 1'b0;
          mcnt[k]++;
        end else begin
          old_w = mm[k][ar];
          new_w = mm[k][aw];
          for (int l = 0; l < 2; l++)
            if (lane[l]) new_w[l*LW +: LW] = din[l*LW +: LW];
          rd_w = (P_RDW[k] == 1 && write && aw == ar) ? new_w : old_w;
          if (read) sbq.push_back(sb_t'{k, cyc + P_LAT[k] - 1, rd_w});
          if (write) mm[k][aw] = new_w;
          if (clear) begin
            mbusy[k] = 1'b1;
            mcnt[k]  = 0;
          end
        end
      end
    end
  end

  // Scoreboard: pop reads that are due and compare every output each cycle.
  always @(negedge clk) begin
    bit  ev [NK];
    sb_t e;
    if (chk_on) begin
      for (int k = 0; k < NK; k++) ev[k] = 1'b0;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        ev[e.k] = 1'b1;
        mlast[e.k] = e.d;
      end
      for (int k = 0; k < NK; k++) begin
        chk($sformatf("sb_busy%0d", k), 32'(bz[k]), 32'(mbusy[k]));
        chk($sformatf("sb_rd_valid%0d", k), 32'(rv[k]), 32'(ev[k]));
        chk($sformatf("sb_dataout%0d", k), 32'(dout[k]), 32'(mlast[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [1:0] en, input logic [5:0] a_w,
                       input logic [9:0] di, input logic rd, input logic [5:0] a_r,
                       input logic cl);
    write = wr; lane = en; aw = a_w; din = di; read = rd; ar = a_r; clear = cl;
    tick(1);
    write = 1'b0; read = 1'b0; clear = 1'b0; lane = 2'b00;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bz[0] && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  task automatic chk_all(input string nm, input logic [9:0] e0, input logic [9:0] e1,
                         input logic [9:0] e2);
    chk({nm, "_d0"}, 32'(dout[0]), 32'(e0));
    chk({nm, "_d1"}, 32'(dout[1]), 32'(e1));
    chk({nm, "_d2"}, 32'(dout[2]), 32'(e2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, bad;
    model_reset();
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd0,  10'h155, 10'h000, 10'h155});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd37, 10'h155, 10'h000, 10'h155});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd63, 10'h155, 10'h000, 10'h155});
    vt.push_back('{1'b1, 2'b11, 6'd0, 10'd12,   1'b0, 6'd0,  10'h155, 10'h000, 10'h155});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd0,  10'd12,  10'd12,  10'd12});
    vt.push_back('{1'b1, 2'b11, 6'd0, 10'd14,   1'b1, 6'd0,  10'd12,  10'd14,  10'd12});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd0,  10'd14,  10'd14,  10'd14});
    vt.push_back('{1'b1, 2'b11, 6'd1, 10'd36,   1'b0, 6'd0,  10'd14,  10'd14,  10'd14});
    vt.push_back('{1'b1, 2'b11, 6'd1, 10'd38,   1'b1, 6'd1,  10'd36,  10'd38,  10'd36});
    vt.push_back('{1'b1, 2'b11, 6'd1, 10'h000,  1'b0, 6'd0,  10'd36,  10'd38,  10'd36});
    vt.push_back('{1'b1, 2'b01, 6'd1, 10'h3FF,  1'b1, 6'd1,  10'h000, 10'h01F, 10'h000});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd1,  10'h01F, 10'h01F, 10'h01F});
    vt.push_back('{1'b1, 2'b11, 6'd5, 10'h000,  1'b0, 6'd0,  10'h01F, 10'h01F, 10'h01F});
    vt.push_back('{1'b1, 2'b10, 6'd5, 10'h3FF,  1'b0, 6'd0,  10'h01F, 10'h01F, 10'h01F});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd5,  10'h3E0, 10'h3E0, 10'h3E0});
    vt.push_back('{1'b1, 2'b00, 6'd5, 10'h155,  1'b0, 6'd0,  10'h3E0, 10'h3E0, 10'h3E0});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd5,  10'h3E0, 10'h3E0, 10'h3E0});
    vt.push_back('{1'b1, 2'b11, 6'd2, 10'd55,   1'b0, 6'd0,  10'h3E0, 10'h3E0, 10'h3E0});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd2,  10'd55,  10'd55,  10'd55});
    vt.push_back('{1'b1, 2'b11, 6'd4, 10'd200,  1'b1, 6'd2,  10'd55,  10'd55,  10'd55});
    vt.push_back('{1'b0, 2'b00, 6'd0, 10'd0,    1'b1, 6'd4,  10'd200, 10'd200, 10'd200});

    tick(3);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("reset_busy%0d", k), 32'(bz[k]), 32'd1);
      chk($sformatf("reset_rd_valid%0d", k), 32'(rv[k]), 32'd0);
    end
    chk_all("reset_dataout", 10'h000, 10'h000, 10'h000);
    chk_on = 1'b1;

    // Accesses held active across the whole fill must be ignored.
    write = 1'b1; lane = 2'b00; aw = 6'd10; din = 10'h2AA; read = 1'b1; ar = 6'd7;
    rst_n = 1'b1;
    nb = 0; bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (bz[0]) nb++;
      if (bz[0] && (rv[0] || rv[1] || rv[2])) bad++;
      tick(1);
    end
    write = 1'b0; read = 1'b0;
    chk("init_busy_cycles", 32'(nb), 32'd64);
    chk("init_rd_valid_while_busy", 32'(bad), 32'd0);
    tick(3);

    foreach (vt[i]) begin
      drive(vt[i].wr, vt[i].en, vt[i].aw, vt[i].di, vt[i].rd, vt[i].ar, 1'b0);
      tick(3);
      chk_all($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].e2);
    end

    // Latency 1 vs 2 and hold after the strobe.
    drive(1'b0, 2'b00, 6'd0, 10'd0, 1'b1, 6'd2, 1'b0);
    chk("lat_v0_edge1", 32'(rv[0]), 32'd1);
    chk("lat_d0_edge1", 32'(dout[0]), 32'd55);
    chk("lat_v2_edge1", 32'(rv[2]), 32'd0);
    tick(1);
    chk("lat_v2_edge2", 32'(rv[2]), 32'd1);
    chk("lat_d2_edge2", 32'(dout[2]), 32'd55);
    chk("lat_v0_edge2", 32'(rv[0]), 32'd0);
    tick(1);
    chk("hold_v2", 32'(rv[2]), 32'd0);
    chk("hold_d2", 32'(dout[2]), 32'd55);

    // Clear re-runs the fill over user data.
    drive(1'b1, 2'b11, 6'd3, 10'd99, 1'b0, 6'd0, 1'b0);
    drive(1'b0, 2'b00, 6'd0, 10'd0, 1'b0, 6'd0, 1'b1);
    count_busy(nb);
    chk("clear_busy_cycles", 32'(nb), 32'd64);
    drive(1'b0, 2'b00, 6'd0, 10'd0, 1'b1, 6'd3, 1'b0);
    tick(2);
    chk_all("clear_readback", 10'h155, 10'h000, 10'h155);

    // Reset in the middle of a fill restarts everything.
    drive(1'b0, 2'b00, 6'd0, 10'd0, 1'b0, 6'd0, 1'b1);
    tick(20);
    #1 rst_n = 1'b0;
    #1;
    chk_all("midinit_rst_dataout", 10'h000, 10'h000, 10'h000);
    for (int k = 0; k < NK; k++)
      chk($sformatf("midinit_rst_busy%0d", k), 32'(bz[k]), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    count_busy(nb);
    chk("restart_busy_cycles", 32'(nb), 32'd64);
    tick(1);

    // Reset while a two-stage read is in flight discards it.
    drive(1'b0, 2'b00, 6'd0, 10'd0, 1'b1, 6'd3, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("inflight_v2", 32'(rv[2]), 32'd0);
    chk("inflight_d2", 32'(dout[2]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);
    for (int k = 0; k < NK; k++)
      chk($sformatf("inflight_after_v%0d", k), 32'(rv[k]), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
